// File: rtl/digit_serial_mult_pkg.sv
// Shared types and latency helper for the digit-serial multiplier.
// The latency helper lets parents size delay lines that run alongside the reduction stage.
package digit_serial_mult_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} dsm_state_t;

  function automatic int digit_serial_mult_lat(input int logq, input int dw);
    return logq / dw;
  endfunction

endpackage

// File: rtl/digit_serial_mult_mul_digit.sv
// Combinational LOGQ x DW unsigned partial-product multiplier, zero latency.
// Kept as its own module so a DSP-mapped implementation can drop in unchanged.
module mul_digit
  import digit_serial_mult_pkg::*;
#(
  parameter int LOGQ = 64,
  parameter int DW   = 16
) (
  input  logic [LOGQ-1:0]    a_i,
  input  logic [DW-1:0]      d_i,
  output logic [LOGQ+DW-1:0] p_o
);

  assign p_o = {{DW{1'b0}}, a_i} * {{LOGQ{1'b0}}, d_i};

endmodule

// File: rtl/digit_serial_mult.sv
// Iterative digit-serial multiplier: C = A*B in LOGQ/DW cycles after acceptance.
// Valid/ready both sides; result held in DONE until consumed, new job may be accepted on the consuming edge.
module digit_serial_mult
  import digit_serial_mult_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int DW     = 16,
  parameter bit FF_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOGQ-1:0]   A,
  input  logic [LOGQ-1:0]   B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*LOGQ-1:0] C,
  output logic              busy
);

  localparam int NDIG = digit_serial_mult_lat(LOGQ, DW);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * LOGQ;

  if (LOGQ % DW != 0) begin : g_bad_dw
    $error("digit_serial_mult: LOGQ must be a multiple of DW");
  end

  dsm_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LOGQ-1:0]  a_q, a_d;
  logic [LOGQ-1:0]  b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    c_q, c_d;

  logic [LOGQ+DW-1:0] pp;
  logic [PW-1:0]      pp_shift;
  logic               last_dig;

  // b_q is shifted right each MUL cycle, so the current digit is always the low DW bits.
  mul_digit #(.LOGQ(LOGQ), .DW(DW)) u_mul (
    .a_i (a_q),
    .d_i (b_q[DW-1:0]),
    .p_o (pp)
  );

  assign pp_shift = PW'(pp) << (DW * cnt_q);
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    c_d      = c_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      MUL: begin
        acc_d = acc_q + pp_shift;
        b_d   = b_q >> DW;
        cnt_d = cnt_q + 1'b1;
        if (last_dig) begin
          state_d = DONE;
          c_d     = acc_q + pp_shift;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Acceptance overrides the DONE->IDLE step so consecutive jobs have no bubble.
    if (in_valid && in_ready) begin
      state_d = MUL;
      a_d     = A;
      b_d     = B;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL);
  assign C         = FF_OUT ? c_q : acc_q;

endmodule

// File: tb/tb_digit_serial_mult.sv
// Directed and randomised checks of digit_serial_mult at DW = 16, 64, 8 and 32.
module tb_digit_serial_mult;
  import digit_serial_mult_pkg::*;

  localparam int LOGQ = 64;
  localparam int NU   = 4;

  function automatic int dw_of(input int u);
    case (u)
      0:       return 16;
      1:       return 64;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid_s  [NU];
  logic         in_ready_s  [NU];
  logic [63:0]  a_s         [NU];
  logic [63:0]  b_s         [NU];
  logic         out_valid_s [NU];
  logic         out_ready_s [NU];
  logic [127:0] c_s         [NU];
  logic         busy_s      [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    digit_serial_mult #(.LOGQ(LOGQ), .DW(dw_of(g)), .FF_OUT(g % 2 == 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .A         (a_s[g]),
      .B         (b_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .C         (c_s[g]),
      .busy      (busy_s[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge, then scramble them to show they are ignored in MUL.
  task automatic start_job(input int u, input logic [63:0] a, input logic [63:0] b);
    in_valid_s[u] = 1'b1;
    a_s[u] = a;
    b_s[u] = b;
    @(posedge clk); #1;
    in_valid_s[u] = 1'b0;
    a_s[u] = ~a;
    b_s[u] = b ^ 64'hA5A5_5A5A_C3C3_3C3C;
  endtask

  task automatic wait_done(input int u, output logic [127:0] c, output int cyc, output bit ir_bad);
    cyc = 0;
    ir_bad = 1'b0;
    while (!out_valid_s[u] && cyc < 200) begin
      if (in_ready_s[u]) ir_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    c = c_s[u];
  endtask

  task automatic do_job(input int u, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp, input string tag);
    logic [127:0] c;
    int cyc;
    bit irb;
    out_ready_s[u] = 1'b1;
    start_job(u, a, b);
    wait_done(u, c, cyc, irb);
    check({tag, "_lat"}, 128'(cyc), 128'(64 / dw_of(u)));
    check({tag, "_c"}, c, exp);
    check({tag, "_rdy_in_mul"}, 128'(irb), 128'(0));
    @(posedge clk); #1;
  endtask

  logic [63:0]  va [3] = '{64'd2, 64'd0, 64'h8000_0000_0000_0000};
  logic [63:0]  vb [3] = '{64'd7, 64'd9, 64'd2};
  logic [127:0] vc [3] = '{128'd14, 128'd0, 128'h1_0000_0000_0000_0000};

  initial begin
    logic [127:0] c, ref_c;
    logic [63:0]  ra, rb;
    int cyc;
    bit irb, bad;

    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      in_valid_s[u]  = 1'b0;
      a_s[u]         = '0;
      b_s[u]         = '0;
      out_ready_s[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid_s[0]), 128'(0));
    check("rst_busy", 128'(busy_s[0]), 128'(0));
    check("rst_c_ff", c_s[0], 128'(0));
    check("rst_c_acc", c_s[1], 128'(0));
    check("rst_in_ready", 128'(in_ready_s[0]), 128'(1));
    rst = 1'b1;

    do_job(0, 64'd3, 64'd5, 128'd15, "basic");
    do_job(0, '1, '1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "max");
    do_job(0, 64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0, "a_zero");

    // Backpressure: result must hold for 10 cycles while out_ready is low.
    out_ready_s[0] = 1'b0;
    start_job(0, 64'h1234, 64'h10000);
    wait_done(0, c, cyc, irb);
    check("bp_lat", 128'(cyc), 128'(4));
    check("bp_c", c, 128'h1234_0000);
    bad = 1'b0;
    repeat (10) begin
      if (!out_valid_s[0] || c_s[0] !== c || in_ready_s[0]) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_hold", 128'(bad), 128'(0));
    check("bp_c_after", c_s[0], 128'h1234_0000);
    out_ready_s[0] = 1'b1;
    #1;
    check("bp_rdy_follows", 128'(in_ready_s[0]), 128'(1));
    @(posedge clk); #1;
    check("bp_drained", 128'(out_valid_s[0]), 128'(0));

    // Back-to-back: next job is accepted on the edge that consumes the previous result.
    for (int j = 0; j < 3; j++) begin
      a_s[0] = va[j];
      b_s[0] = vb[j];
      in_valid_s[0] = 1'b1;
      check($sformatf("b2b%0d_rdy", j), 128'(in_ready_s[0]), 128'(1));
      @(posedge clk); #1;
      check($sformatf("b2b%0d_busy", j), 128'(busy_s[0]), 128'(1));
      if (j == 2) in_valid_s[0] = 1'b0;
      wait_done(0, c, cyc, irb);
      check($sformatf("b2b%0d_lat", j), 128'(cyc), 128'(4));
      check($sformatf("b2b%0d_c", j), c, vc[j]);
    end
    @(posedge clk); #1;
    check("b2b_end_idle", 128'(out_valid_s[0]), 128'(0));

    // Reset at the second edge of a job discards it.
    start_job(0, 64'd9, 64'd9);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mrst_out_valid", 128'(out_valid_s[0]), 128'(0));
    check("mrst_busy", 128'(busy_s[0]), 128'(0));
    check("mrst_in_ready", 128'(in_ready_s[0]), 128'(1));
    bad = 1'b0;
    repeat (6) begin
      if (out_valid_s[0]) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("mrst_no_result", 128'(bad), 128'(0));
    do_job(0, 64'd6, 64'd7, 128'd42, "post_rst");

    do_job(1, '1, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE, "dw64");
    do_job(1, 64'd3, 64'd5, 128'd15, "dw64_small");

    for (int u = 2; u < NU; u++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (n % 97 == 0) ra = '1;
        if (n % 89 == 0) rb = '1;
        ref_c = {64'd0, ra} * {64'd0, rb};
        do_job(u, ra, rb, ref_c, $sformatf("rnd_dw%0d_%0d", dw_of(u), n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_mult.md
Name: digit_serial_mult

Overview:
Iterative digit-serial integer multiplier that produces the full 2*LOGQ-bit product C = A*B consumed by the Montgomery shift-reduction stage.
- Trades the wide combinational multiplier for a LOGQ x DW partial-product array, reused over LOGQ/DW cycles.
- Uses a valid/ready handshake on both sides so it can sit in front of the fixed-latency reduction pipeline.

Parameters:
- LOGQ, 64, operand width in bits.
- DW, 16, digit width of B consumed per cycle. LOGQ % DW must be 0, else elaboration error.
- FF_OUT, 1, 1 = C driven from a register; 0 = C driven from the accumulator directly. Same cycle timing either way, because the accumulator is already registered.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands
- A  input  LOGQ  multiplicand
- B  input  LOGQ  multiplier
- out_valid  output  1  C valid
- out_ready  input  1  downstream accepts C
- C  output  2*LOGQ  product A*B, unsigned
- busy  output  1  high in MUL state

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low; it is sampled only at the posedge of clk with rst == 0.
- Constant: NDIG = LOGQ/DW.
- States:
  - IDLE: in_ready = 1.
  - MUL: counts digits 0..NDIG-1.
  - DONE: out_valid = 1.
- Reset values: state = IDLE, out_valid = 0, busy = 0, digit counter = 0, accumulator = 0, C = 0. in_ready = 1 while reset is held.
- IDLE -> MUL: on an edge with in_valid & in_ready.
  - Latch A and B.
  - Clear the accumulator.
  - Set counter = 0.
- MUL, each edge:
  - acc += (A_reg * B_reg[DW*i +: DW]) << (DW*i), where i = counter.
  - Equivalent right-shifting-accumulator forms are allowed if the final value is identical.
  - The accumulator is 2*LOGQ bits wide. Exact arithmetic, no overflow possible.
  - counter++.
  - After the edge that processes i = NDIG-1, go to DONE.
- Latency: operands accepted at edge k -> out_valid = 1 and C valid in the cycle after edge k+NDIG (NDIG cycles).
- DONE:
  - C and out_valid hold stable while out_ready = 0, for any duration.
  - in_ready = out_ready, which allows back-to-back operation.
  - If out_ready & in_valid: the result is consumed and new operands are latched on the same edge -> MUL. No bubble between jobs.
  - If out_ready & !in_valid: -> IDLE, out_valid = 0.
- in_ready is 0 in MUL. A and B are ignored there. A and B changing during MUL has no effect.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to out_valid.
- busy = (state == MUL).
- Reset mid-operation (MUL or DONE): the in-flight job is discarded. The next cycle is IDLE with out_valid = 0; no partial result is emitted.
- Boundary cases:
  - DW = LOGQ: NDIG = 1, latency 1.
  - A = 0 or B = 0: runs the full NDIG cycles and returns 0. There is no early termination, so latency is fixed.
  - Maximum operands: C = (2^LOGQ - 1)^2 fits exactly in 2*LOGQ bits.

Decomposition:
- Shared package digit_serial_mult_pkg:
  - typedef enum dsm_state_t {IDLE, MUL, DONE}.
  - function digit_serial_mult_lat(LOGQ, DW) returning LOGQ/DW. Parent modules use it to size qH/K delay lines alongside the reduction stage.
- One sub-module, mul_digit: combinational LOGQ x DW unsigned multiplier, output LOGQ+DW bits. It is instantiated once and kept separate so it can be swapped for a DSP-mapped version.
- The FSM, counter and accumulator stay in digit_serial_mult.

Test Plan:
1. Basic product. LOGQ = 64, DW = 16. Send A = 3, B = 5 at edge 0, out_ready = 1 -> out_valid = 1 after edge 4, C = 15. in_ready = 0 during edges 1-3.
2. Maximum operands. A = B = 2^64 - 1 -> C = 0xFFFFFFFFFFFFFFFE_0000000000000001.
3. Backpressure. Hold out_ready = 0 for 10 cycles after out_valid, with A = 0x1234, B = 0x10000 -> C = 0x12340000 and it stays stable. in_ready = 0 until out_ready rises.
4. Back-to-back. Keep in_valid = 1 with 3 jobs (2x7, 0x9, 2^63 x 2) and out_ready = 1 -> results 14, 0, 2^64, each exactly 4 cycles apart, with no idle cycle.
5. Reset mid-operation. Assert rst = 0 at edge 2 of a job -> out_valid stays 0 and state returns to IDLE. A fresh job A = 6, B = 7 then returns 42 with normal latency.
6. Parameter corner. DW = 64: A = 2^64 - 1, B = 2 -> C = 2^65 - 2 one cycle after acceptance. Also random 1000-job regression against a reference model at DW = 8 and DW = 32.
